// File: rtl/tmds_encoder_8b10b_if.sv
// TMDS channel bus: one pixel component plus control bits in, one 10-bit symbol out.
interface tmds_encoder_8b10b_if;
   logic [7:0] din;
   logic       c0;
   logic       c1;
   logic       de;
   logic [9:0] dout;

   // Pixel source side
   modport master (output din, output c0, output c1, output de, input dout);
   // Encoder side
   modport slave  (input din, input c0, input c1, input de, output dout);
endinterface

// File: rtl/tmds_encoder_8b10b.sv
// Per-channel TMDS encoder: 3-stage pipeline with transition minimisation,
// running-disparity DC balancing and control-token insertion during blanking.
module tmds_encoder_8b10b (
   input  logic                  pclk,
   input  logic                  rst,
   tmds_encoder_8b10b_if.slave   tmds
);

   localparam int unsigned DW = 8;   // data byte width
   localparam int unsigned QW = 9;   // transition-minimised word width
   localparam int unsigned SW = 10;  // symbol width
   localparam int unsigned NW = 4;   // popcount width (0..8)
   localparam int unsigned CW = 5;   // running disparity width (-8..+8)
   localparam int unsigned XW = 6;   // widened disparity arithmetic width

   localparam logic [SW-1:0] TOK_00 = 10'h354;
   localparam logic [SW-1:0] TOK_01 = 10'h0AB;
   localparam logic [SW-1:0] TOK_10 = 10'h154;
   localparam logic [SW-1:0] TOK_11 = 10'h2AB;

   localparam logic [NW-1:0] HALF = 4'd4;

   function automatic logic [NW-1:0] popcnt8(input logic [DW-1:0] v);
      logic [NW-1:0] s;
      s = '0;
      for (int i = 0; i < DW; i++) s = s + NW'(v[i]);
      return s;
   endfunction

   // Stage 1 registers
   logic [DW-1:0] din1_q;
   logic          de1_q;
   logic [1:0]    c1_q;
   logic [NW-1:0] n1d_q, n1d_d;

   // Stage 2 registers
   logic [QW-1:0] qm_q, qm_d;
   logic [NW-1:0] n1q_q, n1q_d;
   logic          de2_q;
   logic [1:0]    c2_q;

   // Stage 3 registers
   logic [SW-1:0]        dout_q, dout_d;
   logic signed [CW-1:0] cnt_q, cnt_d;

   // Stage 2 combinational helpers
   logic use_xnor_c;
   logic chain_c;

   // Stage 3 combinational helpers
   logic signed [XW-1:0] diff_c;
   logic signed [XW-1:0] cnt_ext_c;
   logic signed [XW-1:0] qm8_x2_c;
   logic signed [XW-1:0] inv_x2_c;
   logic signed [XW-1:0] cnt_sum_c;

   assign n1d_d = popcnt8(tmds.din);

   // Stage 1: capture inputs and count ones in the data byte
   always_ff @(posedge pclk) begin
      if (rst) begin
         din1_q <= '0;
         de1_q  <= 1'b0;
         c1_q   <= 2'b00;
         n1d_q  <= '0;
      end else begin
         din1_q <= tmds.din;
         de1_q  <= tmds.de;
         c1_q   <= {tmds.c1, tmds.c0};
         n1d_q  <= n1d_d;
      end
   end

   assign use_xnor_c = (n1d_q > HALF) || ((n1d_q == HALF) && !din1_q[0]);

   // Transition-minimising XOR/XNOR chain; bit 8 flags the XOR variant
   always_comb begin
      qm_d    = '0;
      chain_c = din1_q[0];
      qm_d[0] = chain_c;
      for (int i = 1; i < DW; i++) begin
         chain_c = use_xnor_c ? ~(chain_c ^ din1_q[i]) : (chain_c ^ din1_q[i]);
         qm_d[i] = chain_c;
      end
      qm_d[QW-1] = ~use_xnor_c;
   end

   assign n1q_d = popcnt8(qm_d[DW-1:0]);

   // Stage 2: register q_m, its ones count and the delayed control fields
   always_ff @(posedge pclk) begin
      if (rst) begin
         qm_q  <= '0;
         n1q_q <= '0;
         de2_q <= 1'b0;
         c2_q  <= 2'b00;
      end else begin
         qm_q  <= qm_d;
         n1q_q <= n1q_d;
         de2_q <= de1_q;
         c2_q  <= c1_q;
      end
   end

   // n1q - n0q == 2*n1q - 8
   assign diff_c    = $signed({1'b0, n1q_q, 1'b0}) - 6'sd8;
   assign cnt_ext_c = $signed({cnt_q[CW-1], cnt_q});
   assign qm8_x2_c  = $signed({3'b000, qm_q[QW-1], 1'b0});
   assign inv_x2_c  = $signed({3'b000, ~qm_q[QW-1], 1'b0});

   // Symbol selection and running-disparity update
   always_comb begin
      dout_d    = dout_q;
      cnt_sum_c = cnt_ext_c;
      if (!de2_q) begin
         cnt_sum_c = '0;
         unique case (c2_q)
            2'b00:   dout_d = TOK_00;
            2'b01:   dout_d = TOK_01;
            2'b10:   dout_d = TOK_10;
            default: dout_d = TOK_11;
         endcase
      end else if ((cnt_q == '0) || (n1q_q == HALF)) begin
         dout_d = {~qm_q[QW-1], qm_q[QW-1],
                   qm_q[QW-1] ? qm_q[DW-1:0] : ~qm_q[DW-1:0]};
         cnt_sum_c = qm_q[QW-1] ? (cnt_ext_c + diff_c) : (cnt_ext_c - diff_c);
      end else if ((!cnt_q[CW-1] && (n1q_q > HALF)) ||
                   ( cnt_q[CW-1] && (n1q_q < HALF))) begin
         // cnt_q is nonzero here, so a clear sign bit means strictly positive
         dout_d    = {1'b1, qm_q[QW-1], ~qm_q[DW-1:0]};
         cnt_sum_c = cnt_ext_c + qm8_x2_c - diff_c;
      end else begin
         dout_d    = {1'b0, qm_q[QW-1], qm_q[DW-1:0]};
         cnt_sum_c = cnt_ext_c + diff_c - inv_x2_c;
      end
      cnt_d = cnt_sum_c[CW-1:0];
   end

   // Stage 3: output symbol and disparity register
   always_ff @(posedge pclk) begin
      if (rst) begin
         dout_q <= TOK_00;
         cnt_q  <= '0;
      end else begin
         dout_q <= dout_d;
         cnt_q  <= cnt_d;
      end
   end

   assign tmds.dout = dout_q;

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// Self-checking bench for the TMDS encoder: directed cases plus random traffic
// against a behavioural encoder/decoder model.
module tb_tmds_encoder_8b10b;

   typedef struct packed {
      logic [7:0] d;
      logic       e;
      logic [1:0] c;
   } sym_t;

   localparam sym_t BLANK = '{d: 8'h00, e: 1'b0, c: 2'b00};

   logic pclk;
   logic rst;

   tmds_encoder_8b10b_if tmds_if ();

   tmds_encoder_8b10b dut (
      .pclk (pclk),
      .rst  (rst),
      .tmds (tmds_if)
   );

   always #5 pclk = ~pclk;

   int   n_vec;
   int   n_err;
   int   mcnt;
   int   run_disp;
   sym_t pipe0, pipe1;
   logic [9:0] obs[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference encoder: spec rules in plain integer arithmetic, mcnt is the disparity
   function automatic logic [9:0] ref_sym(input sym_t s);
      logic [9:0] o;
      logic [8:0] qm;
      int n1, ones, zeros, b;
      bit xn;
      if (!s.e) begin
         mcnt = 0;
         case (s.c)
            2'b00:   o = 10'h354;
            2'b01:   o = 10'h0AB;
            2'b10:   o = 10'h154;
            default: o = 10'h2AB;
         endcase
         return o;
      end
      n1 = $countones(s.d);
      xn = (n1 > 4) || (n1 == 4 && s.d[0] == 1'b0);
      qm[0] = s.d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = xn ? ~(qm[i-1] ^ s.d[i]) : (qm[i-1] ^ s.d[i]);
      qm[8] = ~xn;
      ones  = $countones(qm[7:0]);
      zeros = 8 - ones;
      b     = qm[8] ? 1 : 0;
      if (mcnt == 0 || ones == zeros) begin
         o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         mcnt += b ? (ones - zeros) : (zeros - ones);
      end else if ((mcnt > 0 && ones > zeros) || (mcnt < 0 && zeros > ones)) begin
         o = {1'b1, qm[8], ~qm[7:0]};
         mcnt += 2 * b + (zeros - ones);
      end else begin
         o = {1'b0, qm[8], qm[7:0]};
         mcnt += (ones - zeros) - 2 * (1 - b);
      end
      return o;
   endfunction

   // Reference decoder: undo optional inversion, then the XOR/XNOR chain
   function automatic logic [7:0] ref_dec(input logic [9:0] s);
      logic [7:0] t, b;
      t = s[9] ? ~s[7:0] : s[7:0];
      b[0] = t[0];
      for (int i = 1; i < 8; i++)
         b[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
      return b;
   endfunction

   // One pixel clock: drive, clock, advance model, compare
   task automatic cyc(input logic r, input logic [7:0] d, input logic e, input logic [1:0] c);
      sym_t s;
      logic [9:0] exp_o;
      rst          = r;
      tmds_if.din  = d;
      tmds_if.de   = e;
      tmds_if.c1   = c[1];
      tmds_if.c0   = c[0];
      @(posedge pclk);
      #1;
      if (r) begin
         pipe0 = BLANK;
         pipe1 = BLANK;
         mcnt  = 0;
         s     = BLANK;
         exp_o = 10'h354;
      end else begin
         s     = pipe1;
         exp_o = ref_sym(s);
         pipe1 = pipe0;
         pipe0 = '{d: d, e: e, c: c};
      end
      chk("dout", 32'(tmds_if.dout), 32'(exp_o));
      if (!r && s.e) begin
         chk("decode", 32'(ref_dec(tmds_if.dout)), 32'(s.d));
         run_disp += 2 * $countones(tmds_if.dout) - 10;
         chk("balance", 32'(run_disp <= 8 && run_disp >= -8), 32'd1);
      end else begin
         run_disp = 0;
      end
      obs.push_back(tmds_if.dout);
   endtask

   initial begin
      pclk        = 1'b0;
      rst         = 1'b1;
      tmds_if.din = '0;
      tmds_if.de  = 1'b0;
      tmds_if.c0  = 1'b0;
      tmds_if.c1  = 1'b0;
      n_vec = 0; n_err = 0; mcnt = 0; run_disp = 0;
      pipe0 = BLANK; pipe1 = BLANK;

      // Reset held with random inputs, then released into blanking
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'($urandom), 1'($urandom), 2'($urandom));
         chk("rst_hold", 32'(tmds_if.dout), 32'h354);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 8'h00, 1'b0, 2'b00);
         chk("rst_release", 32'(tmds_if.dout), 32'h354);
      end

      // Control tokens on consecutive cycles
      obs.delete();
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 2'(i));
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      chk("tok00", 32'(obs[2]), 32'h354);
      chk("tok01", 32'(obs[3]), 32'h0AB);
      chk("tok10", 32'(obs[4]), 32'h154);
      chk("tok11", 32'(obs[5]), 32'h2AB);

      // Repeated 0x00 after blanking walks the disparity
      obs.delete();
      for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1, 2'b00);
      chk("zero_0", 32'(obs[2]), 32'h100);
      chk("zero_1", 32'(obs[3]), 32'h3FF);
      chk("zero_2", 32'(obs[4]), 32'h100);
      chk("zero_3", 32'(obs[5]), 32'h3FF);

      // 0xFF after blanking
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 2'b00);
      obs.delete();
      cyc(1'b0, 8'hFF, 1'b1, 2'b00);
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      chk("ff_first", 32'(obs[2]), 32'h200);

      // A single blanking cycle clears the disparity
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 2'b00);
      obs.delete();
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 2'b00);
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      cyc(1'b0, 8'h00, 1'b1, 2'b00);
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      cyc(1'b0, 8'h00, 1'b0, 2'b00);
      chk("blank_pre", 32'(obs[4]), 32'h100);
      chk("blank_tok", 32'(obs[5]), 32'h354);
      chk("blank_post", 32'(obs[6]), 32'h100);

      // Random traffic with occasional mid-stream reset
      for (int i = 0; i < 20000; i++) begin
         logic r;
         r = ($urandom_range(0, 499) == 0);
         cyc(r, 8'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom));
         if (r) chk("rst_mid", 32'(tmds_if.dout), 32'h354);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
